// File: rtl/lemon_wb_pkg.sv
// Shared defaults, requester indices and packed-bus slicing helper for the write-back scheduler.
package lemon_wb_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 5;
  localparam int unsigned WB_DATA_WIDTH = 32;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_CSR = 2;

  // Widest slice / bus the helper handles: 8 requesters of up to 64 bits.
  localparam int unsigned WB_MAX_W = 64;
  localparam int unsigned WB_BUS_W = 8 * WB_MAX_W;

  function automatic logic [WB_MAX_W-1:0] wb_slice(input logic [WB_BUS_W-1:0] bus,
                                                    input int unsigned         width,
                                                    input int unsigned         idx);
    logic [WB_MAX_W-1:0] mask;
    mask = ~({WB_MAX_W{1'b1}} << width);
    return WB_MAX_W'(bus >> (width * idx)) & mask;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin write-back arbiter; define LEMON_WB_FIXED_PRIO_EN for fixed lowest-index priority.
module wb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic               i_adv,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDXW-1:0]    o_grant_idx
);

  logic w_found;

`ifdef LEMON_WB_FIXED_PRIO_EN
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req_valid[k]) begin
        w_found     = 1'b1;
        o_grant[k]  = 1'b1;
        o_grant_idx = IDXW'(k);
      end
    end
  end
`else
  logic [IDXW-1:0] r_ptr;

  // Search starts at the pointer and wraps, so the last winner becomes lowest priority.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req_valid[(32'(r_ptr) + k) % NUM_REQ]) begin
        w_found                                 = 1'b1;
        o_grant[(32'(r_ptr) + k) % NUM_REQ]     = 1'b1;
        o_grant_idx                             = IDXW'((32'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (o_grant_idx == IDXW'(NUM_REQ - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file write-back scheduler with busy scoreboard; LEMON_WB_FIXED_PRIO_EN selects fixed priority.
module regfile_wb_sched
  import lemon_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
  parameter int unsigned NUM_REQ    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          issue_valid,
  input  logic [ADDR_WIDTH-1:0]         issue_rd,
  input  logic [ADDR_WIDTH-1:0]         chk_rs1,
  input  logic [ADDR_WIDTH-1:0]         chk_rs2,
  output logic                          stall_rs1,
  output logic                          stall_rs2,
  output logic                          stall_rd,
  output logic                          rf_wen,
  output logic [ADDR_WIDTH-1:0]         rf_rd,
  output logic [DATA_WIDTH-1:0]         rf_dataD
);

  localparam int unsigned NREG = 1 << ADDR_WIDTH;
  localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    w_grant;
  logic [IDXW-1:0]       w_idx;
  logic                  w_hs;
  logic [ADDR_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NREG-1:0]       r_busy;
  logic [NREG-1:0]       w_busy_nxt;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_data;

  wb_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .i_adv       (w_hs),
    .o_grant     (w_grant),
    .o_grant_idx (w_idx)
  );

  assign w_hs      = (|req_valid) & rst_n;
  assign req_ready = w_grant & {NUM_REQ{rst_n}};
  assign w_rd      = ADDR_WIDTH'(wb_slice(WB_BUS_W'(req_rd), ADDR_WIDTH, 32'(w_idx)));
  assign w_data    = DATA_WIDTH'(wb_slice(WB_BUS_W'(req_data), DATA_WIDTH, 32'(w_idx)));

  // x0 write-backs are consumed but leave rf_rd/rf_dataD holding their previous values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen  <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      r_wen <= w_hs && (w_rd != '0);
      if (w_hs && (w_rd != '0)) begin
        r_rd   <= w_rd;
        r_data <= w_data;
      end
    end
  end

  // Set is applied after clear so a same-edge new producer keeps the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wen) w_busy_nxt[r_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) w_busy_nxt[issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign stall_rs1 = r_busy[chk_rs1];
  assign stall_rs2 = r_busy[chk_rs2];
  assign stall_rd  = r_busy[issue_rd];
  assign rf_wen    = r_wen;
  assign rf_rd     = r_rd;
  assign rf_dataD  = r_data;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Scoreboard bench for regfile_wb_sched: expected writes queued at grant, compared one cycle later.
module tb_regfile_wb_sched;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_rd;
  logic [NR*DW-1:0] req_data;
  logic             issue_valid;
  logic [AW-1:0]    issue_rd, chk_rs1, chk_rs2;
  logic             stall_rs1, stall_rs2, stall_rd;
  logic             rf_wen;
  logic [AW-1:0]    rf_rd;
  logic [DW-1:0]    rf_dataD;

  logic [AW-1:0] v_rd[NR];
  logic [DW-1:0] v_data[NR];

  typedef struct {
    logic          wen;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_t;

  wb_t           q[$];
  int            m_ptr;
  logic [31:0]   m_busy;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  int            last_g;
  int            n_tests = 0;
  int            n_fail  = 0;

  regfile_wb_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .stall_rs1   (stall_rs1),
    .stall_rs2   (stall_rs2),
    .stall_rd    (stall_rd),
    .rf_wen      (rf_wen),
    .rf_rd       (rf_rd),
    .rf_dataD    (rf_dataD)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_rd   = '0;
    req_data = '0;
    for (int i = 0; i < NR; i++) begin
      req_rd[i*AW +: AW]   = v_rd[i];
      req_data[i*DW +: DW] = v_data[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_grant();
`ifdef LEMON_WB_FIXED_PRIO_EN
    for (int k = 0; k < NR; k++) if (req_valid[k]) return k;
`else
    for (int k = 0; k < NR; k++) if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr  = 0;
    m_busy = '0;
    m_rd   = '0;
    m_data = '0;
    last_g = -1;
  endtask

  // One clock: compare at negedge, advance the model, return 1ns after the next posedge.
  task automatic cycle();
    int            g;
    wb_t           e;
    logic [31:0]   nb;
    logic [NR-1:0] er;
    @(negedge clk);
    g  = exp_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(er));
    check("stall_rs1", 64'(stall_rs1), 64'(m_busy[chk_rs1]));
    check("stall_rs2", 64'(stall_rs2), 64'(m_busy[chk_rs2]));
    check("stall_rd",  64'(stall_rd),  64'(m_busy[issue_rd]));
    if (q.size() > 0) e = q.pop_front();
    else begin e.wen = 1'b0; e.rd = '0; e.data = '0; end
    check("rf_wen", 64'(rf_wen), 64'(e.wen));
    if (e.wen) begin m_rd = e.rd; m_data = e.data; end
    check("rf_rd",    64'(rf_rd),    64'(m_rd));
    check("rf_dataD", 64'(rf_dataD), 64'(m_data));
    nb = m_busy;
    if (e.wen) nb[e.rd] = 1'b0;
    if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
    m_busy = nb;
    last_g = g;
    if (g >= 0) begin
      q.push_back('{wen: (v_rd[g] != 0), rd: v_rd[g], data: v_data[g]});
      m_ptr = (g + 1) % NR;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = '1;
    issue_valid = 1'b0;
    issue_rd    = '0;
    chk_rs1     = '0;
    chk_rs2     = '0;
    for (int i = 0; i < NR; i++) begin
      v_rd[i]   = AW'(i + 1);
      v_data[i] = 32'h1000_0000 + DW'(i);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(req_ready), 64'(0));
    check("reset_wen",   64'(rf_wen),    64'(0));
    rst_n = 1'b1;

    // Continuous three-way contention.
    repeat (7) cycle();
    req_valid = '0;
    cycle();

    // RAW hazard on x5 resolved by an ALU write-back.
    issue_valid = 1'b1; issue_rd = 5;
    cycle();
    issue_valid = 1'b0; chk_rs1 = 5;
    cycle();
    v_rd[0] = 5; v_data[0] = 32'hDEAD_BEEF; req_valid = 3'b001;
    cycle();
    req_valid = '0;
    cycle();
    cycle();

    // x0 write-back is granted but never writes.
    v_rd[1] = 0; v_data[1] = 32'h0000_1234; req_valid = 3'b010; chk_rs2 = 0;
    cycle();
    req_valid = '0;
    cycle();
    v_rd[1] = 2; req_valid = '1;
    cycle();
    req_valid = '0;
    cycle();

    // Write-back clears x7 at the same edge a new producer reserves it.
    issue_valid = 1'b1; issue_rd = 7;
    cycle();
    issue_valid = 1'b0; v_rd[2] = 7; v_data[2] = 32'h7777_0007; req_valid = 3'b100;
    cycle();
    req_valid = '0; issue_valid = 1'b1; issue_rd = 7;
    cycle();
    issue_valid = 1'b0;
    cycle();
    check("same_edge_busy7", 64'(stall_rd), 64'(1));

    // Randomised traffic; rd/data only change once the holder is granted.
    for (int n = 0; n < 60; n++) begin
      req_valid = NR'($urandom);
      chk_rs1   = AW'($urandom);
      chk_rs2   = AW'($urandom);
      issue_rd  = AW'($urandom);
      issue_valid = ($urandom_range(0, 2) == 0) && !m_busy[issue_rd];
      cycle();
      if (last_g >= 0) begin
        v_rd[last_g]   = AW'($urandom);
        v_data[last_g] = $urandom;
      end
    end

    // Reset during a live stream with a busy register pending.
    req_valid = '0; issue_valid = 1'b0;
    cycle();
    cycle();
    issue_valid = 1'b1; issue_rd = 9; chk_rs1 = 9;
    for (int i = 0; i < NR; i++) v_rd[i] = AW'(i + 1);
    req_valid = '1;
    cycle();
    issue_valid = 1'b0;
    cycle();
    cycle();
    check("pre_reset_wen", 64'(rf_wen), 64'(1));
    rst_n = 1'b0;
    #1;
    check("async_wen",   64'(rf_wen),    64'(0));
    check("async_ready", 64'(req_ready), 64'(0));
    check("async_busy",  64'(stall_rs1), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Write-back scheduler for the single-write-port integer register file.
- Arbitrates NUM_REQ write-back requesters (ALU, LSU, CSR) onto the one write port, using valid/ready handshakes and round-robin priority.
- Keeps a per-register busy scoreboard that the issue stage reads for RAW/WAW stall decisions.
- Sits between the execute units and the register file write port (rd / wen / dataD).

Parameters:
- ADDR_WIDTH, 5, register index width; the block tracks 1<<ADDR_WIDTH registers.
- DATA_WIDTH, 32, write-back data width.
- NUM_REQ, 3, number of write-back requesters; legal range 2..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester write-back request.
- req_ready  output  NUM_REQ  per-requester grant; handshake completes on valid&&ready.
- req_rd  input  NUM_REQ*ADDR_WIDTH  packed destination indices; requester i occupies slice i.
- req_data  input  NUM_REQ*DATA_WIDTH  packed write-back data.
- issue_valid  input  1  issue stage reserves a destination this cycle.
- issue_rd  input  ADDR_WIDTH  destination being reserved.
- chk_rs1  input  ADDR_WIDTH  source 1 being checked by issue.
- chk_rs2  input  ADDR_WIDTH  source 2 being checked by issue.
- stall_rs1  output  1  chk_rs1 has a pending write.
- stall_rs2  output  1  chk_rs2 has a pending write.
- stall_rd  output  1  issue_rd has a pending write (WAW hazard).
- rf_wen  output  1  register file write enable.
- rf_rd  output  ADDR_WIDTH  register file write index.
- rf_dataD  output  DATA_WIDTH  register file write data.

Behaviour:
- Reset (async assert, sync release):
  - rf_wen=0, rf_rd=0, rf_dataD=0.
  - All busy bits cleared.
  - Round-robin pointer = 0.
  - req_ready=0 while rst_n is low.
- Arbitration is combinational:
  - Grant goes to the first valid requester at or after the pointer, searching upward with wrap.
  - Exactly one req_ready is high when any req_valid is high; all are low otherwise.
  - req_ready never depends on the requester's own req_ready.
- Pointer update: on a handshake by requester g, pointer <= (g+1) mod NUM_REQ. With no handshake the pointer holds.
- Output stage, 1-cycle latency:
  - A handshake in cycle N drives rf_wen/rf_rd/rf_dataD during cycle N+1.
  - rf_wen is high for exactly one cycle per accepted request.
  - The output stage never stalls, so throughput is 1 write per cycle.
- x0 rule:
  - A request with rd=0 is accepted normally (req_ready high, pointer advances).
  - It produces rf_wen=0 in cycle N+1; rf_rd and rf_dataD hold their previous values.
- Requesters must hold req_rd and req_data stable while req_valid is high and req_ready is low. Dropping req_valid before the grant is permitted.
- Scoreboard, busy[1<<ADDR_WIDTH]:
  - Set: at the posedge where issue_valid=1 and issue_rd!=0.
  - Clear: at the posedge where rf_wen=1, for busy[rf_rd].
  - Set and clear of the same index at the same edge: set wins (a new producer exists).
  - busy[0] is constant 0.
- Stall outputs (combinational from the registered busy bits, no bypass):
  - stall_rs1 = busy[chk_rs1]; stall_rs2 = busy[chk_rs2]; stall_rd = busy[issue_rd].
  - Each is 0 when its index is 0.
  - The register file writes at the same edge the busy bit clears, so a reader the following cycle sees the new data.
- Issue contract: issue_valid must not be asserted while stall_rd=1. If it is violated, the busy bit stays set and clears on the first matching write-back.
- A write-back whose rd is not busy still writes; busy[rd] stays 0.
- Reset mid-operation: any in-flight output-stage write is discarded (rf_wen=0 immediately) and the scoreboard clears.

Optional Feature:
- Macro: LEMON_WB_FIXED_PRIO_EN.
- Defined:
  - Round-robin is replaced by fixed priority; the lowest index wins.
  - The pointer register is removed.
  - The requester ordering guarantee is starvation-possible; this is the team's lowest-area build.
- Undefined: the round-robin behaviour above applies.

Decomposition:
- Package lemon_wb_pkg holds:
  - Default ADDR_WIDTH/DATA_WIDTH localparams.
  - Requester index constants: REQ_ALU=0, REQ_LSU=1, REQ_CSR=2.
  - A function that extracts slice i from the packed req_rd/req_data buses.
- One sub-module, wb_rr_arbiter:
  - Parameter NUM_REQ; inputs req_valid and the pointer-advance strobe.
  - Outputs a one-hot grant and a binary grant index.
  - Contains the pointer and the LEMON_WB_FIXED_PRIO_EN switch.

Test Plan:
- Reset with all three valid asserted, rst_n released -> cycle 0 grant to req0; rf_wen=0 until the first handshake registers; all stall outputs 0.
- req0/1/2 valid continuously with rd=1/2/3 -> grants 0,1,2,0,...; rf_wen high every cycle with rf_rd 1,2,3,1 one cycle after each grant. With LEMON_WB_FIXED_PRIO_EN: req0 wins every cycle.
- issue_valid rd=5, then chk_rs1=5 -> stall_rs1=1 next cycle. ALU writes rd=5 data 0xDEADBEEF -> rf_wen with rf_rd=5 and rf_dataD=0xDEADBEEF; stall_rs1=0 the cycle after.
- Request rd=0 data 0x1234 -> req_ready=1, rf_wen stays 0, pointer advances; chk_rs2=0 -> stall_rs2=0 always.
- Same edge: rf_wen for rd=7 and issue_valid rd=7 -> busy[7] remains 1 and stall_rd=1 for issue_rd=7.
- Assert rst_n=0 mid-stream while rf_wen=1 -> rf_wen drops asynchronously; busy all clear; pointer returns to 0.
